aes_shift_rows_stage: RTL



---
 rtl/aes_shift_rows_stage.sv | 85 ++++++++
 1 files changed

// File: rtl/aes_shift_rows_stage.sv
// AES ShiftRows elastic stage: 1-cycle latency, 2-entry skid buffer, registered in_ready.
// Define AES_SHIFT_ROWS_INV_EN to add per-transaction in_inv selecting InvShiftRows.
module aes_shift_rows_stage #(
    parameter int unsigned word_size  = 8,
    parameter int unsigned array_size = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [0:word_size*array_size-1]   in_data,
`ifdef AES_SHIFT_ROWS_INV_EN
    input  logic                              in_inv,
`endif
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [0:word_size*array_size-1]   out_data
);

    localparam int unsigned width = word_size * array_size;

    if (array_size != 16) begin : g_bad_size
        $error("aes_shift_rows_stage: array_size must be 16");
    end

    // Byte k sits at bits [word_size*k +: word_size], k = 4*col + row.
    function automatic logic [0:width-1] shift(input logic [0:width-1] d, input logic inv);
        logic [0:width-1] res;
        int unsigned      src;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                src = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
                res[word_size*(4*c+r) +: word_size] = d[word_size*(4*src+r) +: word_size];
            end
        end
        return res;
    endfunction

    logic             dir;
    logic             in_fire;
    logic             m_valid;
    logic             s_valid;
    logic [0:width-1] m_data;
    logic [0:width-1] s_data;
    logic [0:width-1] captured;

`ifdef AES_SHIFT_ROWS_INV_EN
    assign dir = in_inv;
`else
    assign dir = 1'b0;
`endif

    // Direction is resolved at capture, so it travels with the transformed data.
    assign captured  = shift(in_data, dir);
    assign in_ready  = !s_valid;
    assign in_fire   = in_valid && in_ready;
    // Masked during reset so no output handshake can complete in the reset cycle.
    assign out_valid = m_valid && !rst;
    assign out_data  = m_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (!m_valid || out_ready) begin
            if (s_valid) begin
                m_data  <= s_data;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (in_fire) begin
                m_data  <= captured;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (in_fire) begin
            s_data  <= captured;
            s_valid <= 1'b1;
        end
    end

endmodule
